// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: operation codes and
// the counter width helper used to size CNT.
package usr_pkg;

    // Operation select encodings for the mode input.
    localparam logic [1:0] MODE_SHR = 2'b00;
    localparam logic [1:0] MODE_SHL = 2'b01;
    localparam logic [1:0] MODE_ROR = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;

    // Bits needed to hold a shift count from 0 up to and including width.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Bus bundle for univ_shift_reg: load/shift controls, serial pins, register
// contents and shift-count status. The par signal exists only when
// USR_PARITY_EN is defined.
interface univ_shift_reg_if
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
);
    localparam int CW = cnt_width(WIDTH);

    logic [WIDTH-1:0] d;
    logic             l;
    logic             en;
    logic [1:0]       mode;
    logic             si_r;
    logic             si_l;
    logic [WIDTH-1:0] q;
    logic             so_r;
    logic             so_l;
    logic [CW-1:0]    cnt;
    logic             done;
`ifdef USR_PARITY_EN
    logic             par;
`endif

    // Driver side: issues loads and shifts, observes the register.
    modport master (
        output d, l, en, mode, si_r, si_l,
`ifdef USR_PARITY_EN
        input  par,
`endif
        input  q, so_r, so_l, cnt, done
    );

    // Register side.
    modport slave (
        input  d, l, en, mode, si_r, si_l,
`ifdef USR_PARITY_EN
        output par,
`endif
        output q, so_r, so_l, cnt, done
    );

endinterface

// File: rtl/usr_shift_counter.sv
// Saturating count of shifts since the last load or reset. clr (the load
// strobe) wins over inc (the shift enable); done decodes cnt == WIDTH.
module usr_shift_counter
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        inc,
    output logic [cnt_width(WIDTH)-1:0] cnt,
    output logic                        done
);
    localparam int            CW      = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    logic [CW-1:0] cnt_r;

    // Count enabled edges, clearing on load and holding once WIDTH is reached.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values and the update order within the block does not matter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (inc && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

    assign cnt  = cnt_r;
    assign done = (cnt_r == CNT_MAX);

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: WIDTH-bit word with parallel load, shift and
// rotate in both directions, serial in/out at both ends and a saturating
// shift counter for parallel-to-serial conversion.
// Optional: define USR_PARITY_EN to add a registered even parity output (par).
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    univ_shift_reg_if.slave  bus
);
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next;

    // Next word: load beats shift, shift beats hold.
    // NOTE: q_next gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        q_next = q_r;
        if (bus.l) begin
            q_next = bus.d;
        end else if (bus.en) begin
            case (bus.mode)
                MODE_SHR: q_next = {bus.si_r, q_r[WIDTH-1:1]};
                MODE_SHL: q_next = {q_r[WIDTH-2:0], bus.si_l};
                MODE_ROR: q_next = {q_r[0], q_r[WIDTH-1:1]};
                MODE_ROL: q_next = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
                default:  q_next = q_r;
            endcase
        end
    end

    // Data register with asynchronous reset to RESET_VAL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r <= RESET_VAL;
        end else begin
            q_r <= q_next;
        end
    end

    assign bus.q    = q_r;
    assign bus.so_r = q_r[0];
    assign bus.so_l = q_r[WIDTH-1];

`ifdef USR_PARITY_EN
    logic par_r;

    // Parity is computed from the next word so it lands with Q on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_r <= ^RESET_VAL;
        end else begin
            par_r <= ^q_next;
        end
    end

    assign bus.par = par_r;
`endif

    usr_shift_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (bus.l),
        .inc  (bus.en),
        .cnt  (bus.cnt),
        .done (bus.done)
    );

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=4): async reset, a vector table
// covering load/shift/rotate/priority/saturation, and a second instance with
// RESET_VAL=4'hC for the reset value and (when USR_PARITY_EN) parity.
module tb_univ_shift_reg;
    import usr_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    univ_shift_reg_if #(.WIDTH(4)) bus  ();
    univ_shift_reg_if #(.WIDTH(4)) bus2 ();

    univ_shift_reg #(.WIDTH(4), .RESET_VAL(4'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    univ_shift_reg #(.WIDTH(4), .RESET_VAL(4'hC)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string      name;
        logic       l;
        logic       en;
        logic [1:0] mode;
        logic       si_r;
        logic       si_l;
        logic [3:0] d;
        logic [3:0] eq;
        logic [2:0] ecnt;
        logic       edone;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge, away from the edge itself.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string name, input logic [3:0] eq,
                               input logic [2:0] ecnt, input logic edone);
        check({name, " q"},    32'(bus.q),    32'(eq));
        check({name, " cnt"},  32'(bus.cnt),  32'(ecnt));
        check({name, " done"}, 32'(bus.done), 32'(edone));
        check({name, " so_r"}, 32'(bus.so_r), 32'(eq[0]));
        check({name, " so_l"}, 32'(bus.so_l), 32'(eq[3]));
`ifdef USR_PARITY_EN
        check({name, " par"},  32'(bus.par),  32'(^eq));
`endif
    endtask

    task automatic drive(input logic l, input logic en, input logic [1:0] mode,
                         input logic si_r, input logic si_l, input logic [3:0] d);
        bus.l    = l;
        bus.en   = en;
        bus.mode = mode;
        bus.si_r = si_r;
        bus.si_l = si_l;
        bus.d    = d;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        drive(1'b0, 1'b0, MODE_SHR, 1'b0, 1'b0, 4'h0);
        bus2.l = 1'b0; bus2.en = 1'b0; bus2.mode = MODE_SHR;
        bus2.si_r = 1'b0; bus2.si_l = 1'b0; bus2.d = 4'h0;

        // Vector table: each row is applied for one edge, then checked.
        vq.push_back('{"load 1011",  1, 0, MODE_SHR, 0, 0, 4'b1011, 4'b1011, 3'd0, 0});
        vq.push_back('{"shr 1",      0, 1, MODE_SHR, 0, 0, 4'h0,    4'b0101, 3'd1, 0});
        vq.push_back('{"shr 2",      0, 1, MODE_SHR, 0, 0, 4'h0,    4'b0010, 3'd2, 0});
        vq.push_back('{"shr 3",      0, 1, MODE_SHR, 0, 0, 4'h0,    4'b0001, 3'd3, 0});
        vq.push_back('{"shr 4",      0, 1, MODE_SHR, 0, 0, 4'h0,    4'b0000, 3'd4, 1});
        vq.push_back('{"shr sat",    0, 1, MODE_SHR, 1, 0, 4'h0,    4'b1000, 3'd4, 1});
        vq.push_back('{"load 1001",  1, 0, MODE_SHR, 0, 0, 4'b1001, 4'b1001, 3'd0, 0});
        vq.push_back('{"rol 1",      0, 1, MODE_ROL, 0, 0, 4'h0,    4'b0011, 3'd1, 0});
        vq.push_back('{"rol 2",      0, 1, MODE_ROL, 0, 0, 4'h0,    4'b0110, 3'd2, 0});
        vq.push_back('{"ror 1",      0, 1, MODE_ROR, 0, 0, 4'h0,    4'b0011, 3'd3, 0});
        vq.push_back('{"load 0",     1, 0, MODE_SHR, 0, 0, 4'h0,    4'b0000, 3'd0, 0});
        vq.push_back('{"shl si1",    0, 1, MODE_SHL, 0, 1, 4'h0,    4'b0001, 3'd1, 0});
        vq.push_back('{"shl si0",    0, 1, MODE_SHL, 1, 0, 4'h0,    4'b0010, 3'd2, 0});
        vq.push_back('{"shl si1b",   0, 1, MODE_SHL, 0, 1, 4'h0,    4'b0101, 3'd3, 0});
        vq.push_back('{"shl si1c",   0, 1, MODE_SHL, 0, 1, 4'h0,    4'b1011, 3'd4, 1});
        vq.push_back('{"load+en",    1, 1, MODE_SHL, 1, 1, 4'h5,    4'h5,    3'd0, 0});
        vq.push_back('{"hold 1",     0, 0, MODE_SHL, 1, 1, 4'hF,    4'h5,    3'd0, 0});
        vq.push_back('{"hold 2",     0, 0, MODE_ROL, 1, 1, 4'hF,    4'h5,    3'd0, 0});
        vq.push_back('{"hold 3",     0, 0, MODE_ROR, 1, 1, 4'hF,    4'h5,    3'd0, 0});
        vq.push_back('{"shr pre",    0, 1, MODE_SHR, 0, 0, 4'h0,    4'b0010, 3'd1, 0});
        vq.push_back('{"load same",  1, 0, MODE_SHR, 0, 0, 4'b0010, 4'b0010, 3'd0, 0});
        vq.push_back('{"mix ror",    0, 1, MODE_ROR, 1, 1, 4'h0,    4'b0001, 3'd1, 0});
        vq.push_back('{"mix rol",    0, 1, MODE_ROL, 1, 1, 4'h0,    4'b0010, 3'd2, 0});
        vq.push_back('{"mix shl",    0, 1, MODE_SHL, 1, 0, 4'h0,    4'b0100, 3'd3, 0});
        vq.push_back('{"mix shr",    0, 1, MODE_SHR, 1, 0, 4'h0,    4'b1010, 3'd4, 1});

        // Reset state after power-up.
        repeat (2) @(posedge clk);
        #1;
        check_state("reset", 4'h0, 3'd0, 1'b0);
        check("reset q2", 32'(bus2.q), 32'hC);
`ifdef USR_PARITY_EN
        check("reset par2", 32'(bus2.par), 32'(1'b0));
`endif
        rst = 1'b0;

        // Asynchronous reset between edges, then held across edges with L=1.
        drive(1'b1, 1'b0, MODE_SHR, 1'b0, 1'b0, 4'hA);
        tick();
        check_state("pre async", 4'hA, 3'd0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_state("async rst", 4'h0, 3'd0, 1'b0);
        drive(1'b1, 1'b0, MODE_SHR, 1'b0, 1'b0, 4'hF);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_state("rst held", 4'h0, 3'd0, 1'b0);
        end
        rst = 1'b0;

        // Reset in the middle of a shift sequence discards it.
        drive(1'b1, 1'b0, MODE_SHR, 1'b0, 1'b0, 4'hF);
        tick();
        drive(1'b0, 1'b1, MODE_SHR, 1'b0, 1'b0, 4'h0);
        tick();
        tick();
        check_state("mid shift", 4'b0011, 3'd2, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_state("mid rst", 4'h0, 3'd0, 1'b0);
        tick();
        rst = 1'b0;

        // Table-driven sequence.
        foreach (vq[i]) begin
            drive(vq[i].l, vq[i].en, vq[i].mode, vq[i].si_r, vq[i].si_l, vq[i].d);
            tick();
            check_state(vq[i].name, vq[i].eq, vq[i].ecnt, vq[i].edone);
        end

        // Second instance: non-zero reset value and parity tracking.
        check("idle q2", 32'(bus2.q), 32'hC);
        bus2.l = 1'b1; bus2.d = 4'h7;
        tick();
        check("load q2", 32'(bus2.q), 32'h7);
`ifdef USR_PARITY_EN
        check("load par2", 32'(bus2.par), 32'(1'b1));
`endif
        bus2.l = 1'b0; bus2.en = 1'b1; bus2.mode = MODE_SHR; bus2.si_r = 1'b0;
        tick();
        check("shr q2", 32'(bus2.q), 32'h3);
        check("shr cnt2", 32'(bus2.cnt), 32'd1);
`ifdef USR_PARITY_EN
        check("shr par2", 32'(bus2.par), 32'(1'b0));
`endif
        bus2.en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised successor to the team's 4-bit load register.
- Holds a WIDTH-bit word and supports parallel load plus shift-right, shift-left, rotate-right and rotate-left, with serial-in/serial-out on both ends.
- A shift counter tracks shifts since the last load and flags DONE after WIDTH shifts, so a parallel word can be serialised without external counting.
- Used as a general-purpose datapath register and as a parallel-to-serial / serial-to-parallel converter.

Parameters:
- WIDTH, 4, register width in bits (>= 2).
- RESET_VAL, 0, value of Q after reset (WIDTH bits).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- R  in  1  reset; asynchronous, active-high.
- D  in  WIDTH  parallel load data.
- L  in  1  parallel load strobe.
- EN  in  1  shift/rotate enable.
- MODE  in  2  operation select: 00 SHR, 01 SHL, 10 ROR, 11 ROL.
- SI_R  in  1  serial input entering at the MSB on SHR.
- SI_L  in  1  serial input entering at the LSB on SHL.
- Q  out  WIDTH  register contents.
- SO_R  out  1  equals Q[0]; combinational from Q.
- SO_L  out  1  equals Q[WIDTH-1]; combinational from Q.
- CNT  out  $clog2(WIDTH+1)  shifts since last load or reset.
- DONE  out  1  high when CNT == WIDTH.

Behaviour:
- Reset: R high forces, immediately and independent of CLK, Q=RESET_VAL, CNT=0, DONE=0. Reset held across edges holds these values. Reset mid-shift discards the partial sequence.
- Priority on each rising edge: R > L > EN > hold.
- L=1:
  - Q<=D, CNT<=0.
  - EN and MODE are ignored on that edge.
- L=0, EN=1, by MODE:
  - SHR: Q<={SI_R, Q[WIDTH-1:1]}.
  - SHL: Q<={Q[WIDTH-2:0], SI_L}.
  - ROR: Q<={Q[0], Q[WIDTH-1:1]}.
  - ROL: Q<={Q[WIDTH-2:0], Q[WIDTH-1]}.
  - In all modes CNT<=CNT+1, saturating at WIDTH; Q keeps shifting after saturation.
- L=0, EN=0: Q and CNT hold.
- Latency: Q reflects an operation one cycle after the edge that samples it. SO_R and SO_L follow Q with no added delay.
- DONE: combinational decode of CNT==WIDTH. After WIDTH shifts following a load it is high in the same cycle CNT reaches WIDTH.
- MODE changing between enabled cycles is legal. Each edge uses the MODE sampled at that edge, and CNT counts every enabled edge regardless of mode.
- Boundaries:
  - CNT never exceeds WIDTH.
  - L and EN together: load wins and CNT clears.
  - Load of the same value still clears CNT.
- No X-propagation tolerance is required on D when L=0.

Optional Feature:
- Macro: USR_PARITY_EN.
- Defined: adds output PAR (1 bit), a registered even parity of the next Q.
  - PAR == ^Q at all times after the first edge.
  - PAR resets to ^RESET_VAL.
  - Updates on the same edge as Q.
- Undefined: PAR port and logic are absent; the rest of the behaviour is unchanged.

Decomposition:
- Package usr_pkg holds:
  - 2-bit mode constants MODE_SHR=2'b00, MODE_SHL=2'b01, MODE_ROR=2'b10, MODE_ROL=2'b11;
  - a function returning the CNT width for a given WIDTH.
- One natural sub-module: usr_shift_counter. It is the saturating CNT/DONE counter with clear (L), increment (EN) and async reset (R), parametrised by WIDTH.
- The data path stays in the top module.

Test Plan (WIDTH=4, RESET_VAL=0 unless noted):
- Async reset: Q=4'hA, assert R between clock edges -> Q=0, CNT=0, DONE=0 before the next edge; holding R for 3 edges with L=1, D=4'hF keeps Q=0.
- Load then serialise: L=1 with D=4'b1011, then 4 edges of EN=1, MODE=SHR, SI_R=0 -> SO_R sequence 1,1,0,1; Q=0 after the 4th edge; CNT 1,2,3,4; DONE=1 after the 4th edge, CNT stays 4 after a 5th shift.
- Rotate: load 4'b1001, 2 edges of ROL -> 4'b0011 then 4'b0110; then one ROR -> 4'b0011.
- Serial-in left: Q=0, SHL with SI_L=1,0,1,1 over 4 edges -> Q=4'b1011, DONE=1.
- Priority: L=1, EN=1, MODE=SHL, D=4'h5 on the same edge -> Q=4'h5, CNT=0; EN=0 for 3 edges -> Q and CNT hold.
- RESET_VAL=4'hC, with USR_PARITY_EN defined -> after reset Q=4'hC, PAR=0; load 4'h7 -> PAR=1; one SHR with SI_R=0 -> Q=4'h3, PAR=0.
